// File: rtl/key_event_filter_if.sv
// key_event_filter_if
// Bundles the frame strobe and keycode input with the filtered key outputs.
// The design uses the slave modport. The keycode source / menu side uses master.
//   frame_clk  : ~60 Hz frame strobe, sampled as data
//   keycode    : raw 8-bit USB keycode, 8'h00 = no key
//   key_up     : one-cycle pulse per Up (8'h52) event
//   key_down   : one-cycle pulse per Down (8'h51) event
//   key_enter  : one-cycle pulse per Enter (8'h58) event
//   key_held   : level, high while a qualified key is held
//   last_key   : code of the most recent qualified key
interface key_event_filter_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       key_up;
  logic       key_down;
  logic       key_enter;
  logic       key_held;
  logic [7:0] last_key;

  modport master (
    output frame_clk, keycode,
    input  key_up, key_down, key_enter, key_held, last_key
  );

  modport slave (
    input  frame_clk, keycode,
    output key_up, key_down, key_enter, key_held, last_key
  );
endinterface

// File: rtl/key_event_filter.sv
// key_event_filter
// Samples the raw keycode once per video frame, debounces it and turns a held
// Up/Down/Enter key into single-cycle press events. Up/Down optionally auto-repeat.
// Optional feature macro: KEYFILT_AUTOREPEAT_EN (defined = Up/Down auto-repeat).
// Ports:
//   Clk   : 50 MHz system clock, the only clock
//   Reset : synchronous active-high reset
//   kif   : key_event_filter_if.slave (frame_clk, keycode in; events, key_held, last_key out)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_LOCKOUT  | after reset; wait for a no-key tick before accepting presses
// S_IDLE     | no valid key held
// S_DEBOUNCE | valid key seen, counting stable frames in cnt
// S_PRESSED  | first event fired; counting toward first repeat in rcnt
// S_REPEAT   | auto-repeating Up/Down every REPEAT_RATE frames
module key_event_filter #(
  parameter int STABLE_FRAMES = 2,
  parameter int REPEAT_DELAY  = 30,
  parameter int REPEAT_RATE   = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  key_event_filter_if.slave  kif
);

  typedef enum logic [2:0] {
    S_LOCKOUT,
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_REPEAT
  } state_t;

  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_ENTER = 8'h58;
  localparam logic [7:0] STABLE_C  = 8'(STABLE_FRAMES);

  state_t     r_state;
  logic       r_frame_d;
  logic       r_tick;
  logic [7:0] r_held;
  logic [7:0] r_cnt;
  logic       r_key_up;
  logic       r_key_down;
  logic       r_key_enter;
  logic       r_key_held;
  logic [7:0] r_last_key;

  logic       w_valid;
  logic       w_same;
  logic [7:0] w_cnt_inc;

  assign w_valid   = (kif.keycode == KEY_UP) || (kif.keycode == KEY_DOWN) ||
                     (kif.keycode == KEY_ENTER);
  assign w_same    = (kif.keycode == r_held);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;

`ifdef KEYFILT_AUTOREPEAT_EN
  localparam logic [7:0] REPEAT_DELAY_C = 8'(REPEAT_DELAY);
  localparam logic [7:0] REPEAT_RATE_C  = 8'(REPEAT_RATE);

  logic [7:0] r_rcnt;
  logic [7:0] w_rcnt_inc;
  logic       w_is_updown;

  assign w_rcnt_inc  = (r_rcnt == 8'hFF) ? 8'hFF : r_rcnt + 8'd1;
  assign w_is_updown = (r_held == KEY_UP) || (r_held == KEY_DOWN);
`else
  // Repeat timing has no effect when auto-repeat is compiled out.
  logic [15:0] w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = {8'(REPEAT_DELAY), 8'(REPEAT_RATE)};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_LOCKOUT;
      r_frame_d   <= 1'b0;
      r_tick      <= 1'b0;
      r_held      <= 8'h00;
      r_cnt       <= 8'h00;
      r_key_up    <= 1'b0;
      r_key_down  <= 1'b0;
      r_key_enter <= 1'b0;
      r_key_held  <= 1'b0;
      r_last_key  <= 8'h00;
`ifdef KEYFILT_AUTOREPEAT_EN
      r_rcnt      <= 8'h00;
`endif
    end else begin
      r_frame_d   <= kif.frame_clk;
      r_tick      <= kif.frame_clk & ~r_frame_d;
      r_key_up    <= 1'b0;
      r_key_down  <= 1'b0;
      r_key_enter <= 1'b0;

      if (r_tick) begin
        if (r_state == S_LOCKOUT) begin
          if (kif.keycode == 8'h00) r_state <= S_IDLE;
        end else if (r_state != S_IDLE && w_same) begin
          // Same key still held: advance whichever counter the state owns.
          case (r_state)
            S_DEBOUNCE: begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc >= STABLE_C) begin
                {r_key_up, r_key_down, r_key_enter} <=
                  {r_held == KEY_UP, r_held == KEY_DOWN, r_held == KEY_ENTER};
                r_last_key <= r_held;
                r_key_held <= 1'b1;
                r_state    <= S_PRESSED;
`ifdef KEYFILT_AUTOREPEAT_EN
                r_rcnt     <= 8'h00;
`endif
              end
            end
`ifdef KEYFILT_AUTOREPEAT_EN
            S_PRESSED: begin
              if (w_is_updown && w_rcnt_inc == REPEAT_DELAY_C) begin
                {r_key_up, r_key_down, r_key_enter} <=
                  {r_held == KEY_UP, r_held == KEY_DOWN, 1'b0};
                r_last_key <= r_held;
                r_rcnt     <= 8'h00;
                r_state    <= S_REPEAT;
              end else begin
                r_rcnt <= w_rcnt_inc;
              end
            end
            S_REPEAT: begin
              if (w_rcnt_inc == REPEAT_RATE_C) begin
                {r_key_up, r_key_down, r_key_enter} <=
                  {r_held == KEY_UP, r_held == KEY_DOWN, 1'b0};
                r_last_key <= r_held;
                r_rcnt     <= 8'h00;
              end else begin
                r_rcnt <= w_rcnt_inc;
              end
            end
`endif
            default: ;
          endcase
        end else if (w_valid) begin
          // New valid key (from IDLE or a key change): restart debounce.
          r_held <= kif.keycode;
          r_cnt  <= 8'd1;
          if (STABLE_FRAMES == 1) begin
            {r_key_up, r_key_down, r_key_enter} <=
              {kif.keycode == KEY_UP, kif.keycode == KEY_DOWN, kif.keycode == KEY_ENTER};
            r_last_key <= kif.keycode;
            r_key_held <= 1'b1;
            r_state    <= S_PRESSED;
`ifdef KEYFILT_AUTOREPEAT_EN
            r_rcnt     <= 8'h00;
`endif
          end else begin
            r_key_held <= 1'b0;
            r_state    <= S_DEBOUNCE;
          end
        end else begin
          r_key_held <= 1'b0;
          r_state    <= S_IDLE;
        end
      end
    end
  end

  assign kif.key_up    = r_key_up;
  assign kif.key_down  = r_key_down;
  assign kif.key_enter = r_key_enter;
  assign kif.key_held  = r_key_held;
  assign kif.last_key  = r_last_key;

endmodule

// File: tb/tb_key_event_filter.sv
module tb_key_event_filter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  key_event_filter_if kif ();

  key_event_filter #(
    .STABLE_FRAMES(2),
    .REPEAT_DELAY (30),
    .REPEAT_RATE  (6)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .kif  (kif.slave)
  );

  int checks = 0;
  int errors = 0;
  int tick_num = 0;
  int n_up = 0, n_down = 0, n_enter = 0, n_multi = 0, n_wide = 0;
  int down_ticks[$];
  logic prev_any = 1'b0;

  // Event monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    logic any;
    any = (kif.key_up === 1'b1) || (kif.key_down === 1'b1) || (kif.key_enter === 1'b1);
    if (kif.key_up === 1'b1) n_up++;
    if (kif.key_down === 1'b1) begin
      n_down++;
      down_ticks.push_back(tick_num);
    end
    if (kif.key_enter === 1'b1) n_enter++;
    if ((int'(kif.key_up === 1'b1) + int'(kif.key_down === 1'b1) + int'(kif.key_enter === 1'b1)) > 1)
      n_multi++;
    if (prev_any && any) n_wide++;
    prev_any = any;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    Reset = 1'b1;
    kif.frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_tick(input logic [7:0] kc);
    kif.keycode = kc;
    kif.frame_clk = 1'b1;
    tick_num++;
    @(negedge Clk);
    kif.frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset();
    int b_up;
    kif.keycode = 8'h00;
    apply_reset();
    checks++; if (kif.key_up !== 1'b0 || kif.key_down !== 1'b0 || kif.key_enter !== 1'b0) begin
      errors++; $display("FAIL reset_events: got %b%b%b want 000", kif.key_up, kif.key_down, kif.key_enter); end
    checks++; if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL reset_key_held: got %b want 0", kif.key_held); end
    checks++; if (kif.last_key !== 8'h00) begin
      errors++; $display("FAIL reset_last_key: got %h want 00", kif.last_key); end
    // Reset lands in lockout: a key without a prior release gives nothing.
    b_up = n_up;
    repeat (3) do_tick(8'h52);
    checks++; if (n_up !== b_up) begin
      errors++; $display("FAIL reset_lockout: got %0d up pulses want 0", n_up - b_up); end
  endtask

  task automatic test_first_press();
    int b_up;
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    b_up = n_up;
    do_tick(8'h52);
    checks++; if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL debounce_held: got %b want 0", kif.key_held); end
    kif.keycode = 8'h52;
    kif.frame_clk = 1'b1;
    tick_num++;
    @(negedge Clk);
    checks++; if (kif.key_up !== 1'b0) begin
      errors++; $display("FAIL up_early: got %b want 0", kif.key_up); end
    kif.frame_clk = 1'b0;
    @(negedge Clk);
    checks++; if (kif.key_up !== 1'b1) begin
      errors++; $display("FAIL up_latency: got %b want 1", kif.key_up); end
    checks++; if (kif.last_key !== 8'h52) begin
      errors++; $display("FAIL up_last_key: got %h want 52", kif.last_key); end
    checks++; if (kif.key_held !== 1'b1) begin
      errors++; $display("FAIL up_key_held: got %b want 1", kif.key_held); end
    @(negedge Clk);
    checks++; if (kif.key_up !== 1'b0) begin
      errors++; $display("FAIL up_width: got %b want 0", kif.key_up); end
    repeat (2) @(negedge Clk);
    checks++; if (n_up - b_up !== 1) begin
      errors++; $display("FAIL up_count: got %0d want 1", n_up - b_up); end
  endtask

  task automatic test_enter_hold();
    int b_en, b_ud;
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    b_en = n_enter; b_ud = n_up + n_down;
    for (int i = 0; i < 100; i++) do_tick(8'h58);
    checks++; if (n_enter - b_en !== 1) begin
      errors++; $display("FAIL enter_count: got %0d want 1", n_enter - b_en); end
    checks++; if (n_up + n_down - b_ud !== 0) begin
      errors++; $display("FAIL enter_other: got %0d want 0", n_up + n_down - b_ud); end
    checks++; if (kif.last_key !== 8'h58) begin
      errors++; $display("FAIL enter_last_key: got %h want 58", kif.last_key); end
    do_tick(8'h00);
    checks++; if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL enter_release_held: got %b want 0", kif.key_held); end
    checks++; if (kif.last_key !== 8'h58) begin
      errors++; $display("FAIL enter_release_last: got %h want 58", kif.last_key); end
  endtask

  task automatic test_down_repeat();
    int base, start;
    int exp_t[$];
`ifdef KEYFILT_AUTOREPEAT_EN
    exp_t = '{2, 32, 38, 44, 50};
`else
    exp_t = '{2};
`endif
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    base = tick_num;
    start = down_ticks.size();
    for (int i = 0; i < 50; i++) do_tick(8'h51);
    checks++; if (down_ticks.size() - start !== exp_t.size()) begin
      errors++; $display("FAIL down_repeat_count: got %0d want %0d", down_ticks.size() - start, exp_t.size()); end
    else begin
      for (int i = 0; i < exp_t.size(); i++) begin
        checks++; if (down_ticks[start + i] - base !== exp_t[i]) begin
          errors++; $display("FAIL down_repeat_tick%0d: got %0d want %0d", i, down_ticks[start + i] - base, exp_t[i]); end
      end
    end
    checks++; if (kif.key_held !== 1'b1) begin
      errors++; $display("FAIL down_held: got %b want 1", kif.key_held); end
    do_tick(8'h00);
  endtask

  task automatic test_reset_mid_press();
    int b_up;
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    b_up = n_up;
    repeat (3) do_tick(8'h52);
    checks++; if (n_up - b_up !== 1) begin
      errors++; $display("FAIL midreset_pre: got %0d want 1", n_up - b_up); end
    // Reset asserted across a tick while the key stays down.
    b_up = n_up;
    Reset = 1'b1;
    do_tick(8'h52);
    Reset = 1'b0;
    checks++; if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL midreset_held: got %b want 0", kif.key_held); end
    repeat (4) do_tick(8'h52);
    checks++; if (n_up !== b_up) begin
      errors++; $display("FAIL midreset_no_event: got %0d want 0", n_up - b_up); end
    do_tick(8'h00);
    repeat (2) do_tick(8'h52);
    checks++; if (n_up - b_up !== 1) begin
      errors++; $display("FAIL midreset_repress: got %0d want 1", n_up - b_up); end
  endtask

  task automatic test_key_switch();
    int b_up, b_dn, base, start;
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    b_up = n_up; b_dn = n_down; base = tick_num; start = down_ticks.size();
    do_tick(8'h52);
    do_tick(8'h51);
    do_tick(8'h51);
    checks++; if (n_up !== b_up) begin
      errors++; $display("FAIL switch_no_up: got %0d want 0", n_up - b_up); end
    checks++; if (n_down - b_dn !== 1) begin
      errors++; $display("FAIL switch_down_count: got %0d want 1", n_down - b_dn); end
    else begin
      checks++; if (down_ticks[start] - base !== 3) begin
        errors++; $display("FAIL switch_down_tick: got %0d want 3", down_ticks[start] - base); end
    end
    checks++; if (kif.last_key !== 8'h51) begin
      errors++; $display("FAIL switch_last_key: got %h want 51", kif.last_key); end
  endtask

  task automatic test_invalid();
    int b_all;
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    b_all = n_up + n_down + n_enter;
    repeat (3) do_tick(8'h41);
    do_tick(8'h52);
    do_tick(8'h00);
    do_tick(8'h52);
    checks++; if (n_up + n_down + n_enter !== b_all) begin
      errors++; $display("FAIL invalid_no_event: got %0d want 0", n_up + n_down + n_enter - b_all); end
    do_tick(8'h52);
    checks++; if (n_up + n_down + n_enter - b_all !== 1) begin
      errors++; $display("FAIL invalid_then_press: got %0d want 1", n_up + n_down + n_enter - b_all); end
  endtask

  task automatic test_long_frame();
    int b_up;
    kif.keycode = 8'h00;
    apply_reset();
    do_tick(8'h00);
    b_up = n_up;
    kif.keycode = 8'h52;
    kif.frame_clk = 1'b1;
    tick_num++;
    repeat (1000) @(negedge Clk);
    kif.frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    checks++; if (n_up !== b_up) begin
      errors++; $display("FAIL long_frame_no_event: got %0d want 0", n_up - b_up); end
    checks++; if (kif.key_held !== 1'b0) begin
      errors++; $display("FAIL long_frame_held: got %b want 0", kif.key_held); end
    do_tick(8'h52);
    checks++; if (n_up - b_up !== 1) begin
      errors++; $display("FAIL long_frame_next: got %0d want 1", n_up - b_up); end
  endtask

  initial begin
    kif.keycode = 8'h00;
    kif.frame_clk = 1'b0;
    test_reset();
    test_first_press();
    test_enter_hold();
    test_down_repeat();
    test_reset_mid_press();
    test_key_switch();
    test_invalid();
    test_long_frame();
    checks++; if (n_multi !== 0) begin
      errors++; $display("FAIL one_hot: got %0d multi-hot cycles want 0", n_multi); end
    checks++; if (n_wide !== 0) begin
      errors++; $display("FAIL pulse_width: got %0d wide pulses want 0", n_wide); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
